// File: rtl/transform_zigzag_scan.sv
// transform_zigzag_scan: registers one 4x4 raster block of 16-bit coefficients,
// streams it in frame zigzag order (full block, AC-only or 2x2 chroma DC),
// saturates each coefficient to 12 bits and reports the nonzero count and
// clip status when the block completes.
module transform_zigzag_scan (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          mode,
    input  logic [255:0]        blk_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [11:0]  out_coeff,
    output logic [3:0]          out_idx,
    output logic                out_last,
    output logic                done,
    output logic [4:0]          total_coeff,
    output logic                sat_flag
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_next;

    logic [255:0]               blk_q;
    logic [1:0]                 mode_q;
    logic [3:0]                 cnt;
    logic [4:0]                 nz_acc;
    logic                       sat_acc;

    logic [3:0]                 raster;
    logic                       is_last;
    logic signed [DATA_W-1:0]   cur_raw;
    logic signed [COEF_W-1:0]   cur_sat;
    logic                       cur_clip;
    logic                       cur_nz;
    logic                       accept;
    logic                       fire;
    logic [4:0]                 nz_next;
    logic                       sat_next;

    // Frame zigzag: scan position -> raster index within the 4x4 block.
    function automatic logic [3:0] zigzag(input logic [3:0] pos);
        logic [3:0] r;
        case (pos)
            4'd0:    r = 4'd0;
            4'd1:    r = 4'd1;
            4'd2:    r = 4'd4;
            4'd3:    r = 4'd8;
            4'd4:    r = 4'd5;
            4'd5:    r = 4'd2;
            4'd6:    r = 4'd3;
            4'd7:    r = 4'd6;
            4'd8:    r = 4'd9;
            4'd9:    r = 4'd12;
            4'd10:   r = 4'd13;
            4'd11:   r = 4'd10;
            4'd12:   r = 4'd7;
            4'd13:   r = 4'd11;
            4'd14:   r = 4'd14;
            default: r = 4'd15;
        endcase
        return r;
    endfunction

    function automatic logic is_clipped(input logic signed [DATA_W-1:0] v);
        return (v > 16'sh07FF) || (v < 16'shF800);
    endfunction

    function automatic logic signed [COEF_W-1:0] saturate(input logic signed [DATA_W-1:0] v);
        if (v > 16'sh07FF)
            return 12'sh7FF;
        else if (v < 16'shF800)
            return 12'sh800;
        else
            return v[COEF_W-1:0];
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SCAN;
            SCAN:    if (fire && is_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and stream outputs; stream fields are forced to 0 outside SCAN.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == SCAN);
        done      = (state == DONE);
        out_coeff = out_valid ? cur_sat : '0;
        out_idx   = out_valid ? cnt : '0;
        out_last  = out_valid ? is_last : 1'b0;
    end

    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;

    // Map the current ordinal to a raster slot and locate the block end per mode.
    always_comb begin
        case (mode_q)
            2'd1: begin
                raster  = zigzag(cnt + 4'd1);
                is_last = (cnt == 4'd14);
            end
            2'd2: begin
                raster  = cnt;
                is_last = (cnt == 4'd3);
            end
            default: begin
                raster  = zigzag(cnt);
                is_last = (cnt == 4'd15);
            end
        endcase
    end

    // Current coefficient: select, saturate, and fold into the block statistics.
    always_comb begin
        cur_raw  = blk_q[{raster, 4'b0000} +: DATA_W];
        cur_sat  = saturate(cur_raw);
        cur_clip = is_clipped(cur_raw);
        cur_nz   = (cur_raw != '0);
        nz_next  = nz_acc + {4'b0000, cur_nz};
        sat_next = sat_acc | cur_clip;
    end

    // Block capture, ordinal advance and per-block statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q       <= '0;
            mode_q      <= '0;
            cnt         <= '0;
            nz_acc      <= '0;
            sat_acc     <= 1'b0;
            total_coeff <= '0;
            sat_flag    <= 1'b0;
        end else if (accept) begin
            blk_q   <= blk_in;
            mode_q  <= mode;
            cnt     <= '0;
            nz_acc  <= '0;
            sat_acc <= 1'b0;
        end else if (fire) begin
            cnt     <= cnt + 4'd1;
            nz_acc  <= nz_next;
            sat_acc <= sat_next;
            // Results publish on the edge that moves the FSM into DONE.
            if (is_last) begin
                total_coeff <= nz_next;
                sat_flag    <= sat_next;
            end
        end
    end

endmodule

// File: tb/tb_transform_zigzag_scan.sv
// Bench for transform_zigzag_scan: directed blocks from the test plan followed
// by randomized blocks, all checked against a list-based zigzag model.
module tb_transform_zigzag_scan;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [1:0]         mode = 2'd0;
    logic [255:0]       blk_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [11:0] out_coeff;
    logic [3:0]         out_idx;
    logic               out_last;
    logic               done;
    logic [4:0]         total_coeff;
    logic               sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    int zz [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
    int exp_v [16];
    int exp_n;
    int exp_tc;
    int exp_sat;

    transform_zigzag_scan dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode        (mode),
        .blk_in      (blk_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_coeff   (out_coeff),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .done        (done),
        .total_coeff (total_coeff),
        .sat_flag    (sat_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: list of raster slots to emit, then saturate/count each value.
    task automatic model(input logic [255:0] b, input logic [1:0] m);
        int src[$];
        logic signed [15:0] t;
        int v;
        src = {};
        if (m == 2'd2) begin
            for (int k = 0; k < 4; k++) src.push_back(k);
        end else if (m == 2'd1) begin
            for (int k = 1; k < 16; k++) src.push_back(zz[k]);
        end else begin
            for (int k = 0; k < 16; k++) src.push_back(zz[k]);
        end
        exp_n = src.size();
        exp_tc = 0;
        exp_sat = 0;
        for (int i = 0; i < exp_n; i++) begin
            t = b[16*src[i] +: 16];
            v = int'(t);
            if (v != 0) exp_tc++;
            if (v > 2047) begin
                exp_v[i] = 2047;
                exp_sat = 1;
            end else if (v < -2048) begin
                exp_v[i] = -2048;
                exp_sat = 1;
            end else begin
                exp_v[i] = v;
            end
        end
    endtask

    function automatic logic [255:0] pack(input int vals [16]);
        logic [255:0] b;
        for (int r = 0; r < 16; r++) b[16*r +: 16] = 16'(vals[r]);
        return b;
    endfunction

    function automatic logic [15:0] rand_coef();
        int v;
        int edges [6] = '{2047, 2048, -2048, -2049, 32767, -32768};
        case ($urandom_range(0, 3))
            0:       v = 0;
            1:       v = int'($urandom_range(0, 200)) - 100;
            2:       v = int'($urandom);
            default: v = edges[$urandom_range(0, 5)];
        endcase
        return 16'(v);
    endfunction

    function automatic logic [255:0] rand_blk();
        logic [255:0] b;
        for (int r = 0; r < 16; r++) b[16*r +: 16] = rand_coef();
        return b;
    endfunction

    function automatic logic rdy(input int pat, input int c);
        if (pat == 0) return 1'b1;
        if (pat == 1) return (c % 4 == 0) || (c % 4 == 3);
        return 1'(($urandom_range(0, 1)));
    endfunction

    // Checks one stream cycle at ordinal k (called #1 after an edge).
    task automatic check_stream(input int k);
        check($sformatf("out_valid[%0d]", k), int'(out_valid), 1);
        check($sformatf("in_ready_busy[%0d]", k), int'(in_ready), 0);
        check($sformatf("done_busy[%0d]", k), int'(done), 0);
        check($sformatf("out_coeff[%0d]", k), int'(out_coeff), exp_v[k]);
        check($sformatf("out_idx[%0d]", k), int'(out_idx), k);
        check($sformatf("out_last[%0d]", k), int'(out_last), (k == exp_n - 1) ? 1 : 0);
    endtask

    task automatic offer_and_accept(input logic [255:0] b, input logic [1:0] m);
        int w;
        in_valid = 1'b1;
        blk_in   = b;
        mode     = m;
        model(b, m);
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("accept_wait", int'(in_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic run_block(input logic [255:0] b, input logic [1:0] m, input int pat,
                             input bit hold, input logic [255:0] nb, input logic [1:0] nm);
        int k;
        int c;
        offer_and_accept(b, m);
        if (hold) begin
            blk_in = nb;
            mode   = nm;
        end else begin
            in_valid = 1'b0;
            blk_in   = rand_blk();
            mode     = 2'($urandom_range(0, 3));
        end
        k = 0;
        c = 0;
        while (k < exp_n && c < 200) begin
            check_stream(k);
            out_ready = rdy(pat, c);
            @(posedge clk); #1;
            if (out_ready) k++;
            c++;
        end
        out_ready = 1'b0;
        check("stream_complete", k, exp_n);
        check("done_pulse", int'(done), 1);
        check("in_ready_in_done", int'(in_ready), 0);
        check("out_valid_in_done", int'(out_valid), 0);
        check("total_coeff", int'(total_coeff), exp_tc);
        check("sat_flag", int'(sat_flag), exp_sat);
        @(posedge clk); #1;
        check("in_ready_after", int'(in_ready), 1);
        check("done_after", int'(done), 0);
        check("total_hold", int'(total_coeff), exp_tc);
    endtask

    initial begin
        int vals [16];
        logic [255:0] b;
        logic [255:0] nb;
        int saved_tc;

        // Reset state
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_coeff", int'(out_coeff), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_done", int'(done), 0);
        check("rst_total", int'(total_coeff), 0);
        check("rst_sat", int'(sat_flag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Mode 0 and mode 1, raster r = r+1
        for (int r = 0; r < 16; r++) vals[r] = r + 1;
        b = pack(vals);
        run_block(b, 2'd0, 0, 1'b0, '0, 2'd0);
        run_block(b, 2'd1, 0, 1'b0, '0, 2'd0);

        // Mode 2: 7,0,-3,0 then 99s
        for (int r = 0; r < 16; r++) vals[r] = 99;
        vals[0] = 7; vals[1] = 0; vals[2] = -3; vals[3] = 0;
        run_block(pack(vals), 2'd2, 0, 1'b0, '0, 2'd0);

        // Saturation, mode 0
        for (int r = 0; r < 16; r++) vals[r] = 0;
        vals[0] = 3000; vals[1] = -5000;
        run_block(pack(vals), 2'd0, 0, 1'b0, '0, 2'd0);

        // Backpressure 1,0,0,1 with the next block held on the input throughout
        b  = rand_blk();
        nb = rand_blk();
        run_block(b, 2'd0, 1, 1'b1, nb, 2'd0);
        run_block(nb, 2'd0, 0, 1'b0, '0, 2'd0);
        saved_tc = exp_tc;

        // Reset at ordinal 7 of a mode 0 block
        offer_and_accept(rand_blk(), 2'd0);
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check_stream(k);
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("pre_reset_idx", int'(out_idx), 7);
        check("pre_reset_total", int'(total_coeff), saved_tc);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_out_coeff", int'(out_coeff), 0);
        check("mid_rst_out_idx", int'(out_idx), 0);
        check("mid_rst_out_last", int'(out_last), 0);
        check("mid_rst_total", int'(total_coeff), 0);
        check("mid_rst_sat", int'(sat_flag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_done", int'(done), 0);
            check("post_rst_idle", int'(in_ready), 1);
        end
        run_block(rand_blk(), 2'd0, 0, 1'b0, '0, 2'd0);

        // Randomized blocks, all modes, random backpressure
        for (int i = 0; i < 24; i++) begin
            run_block(rand_blk(), 2'($urandom_range(0, 3)), 2, 1'b0, '0, 2'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
